fetch_control: RTL and testbench

FETCH_CONTROL -- requirements
Module: fetch_control

---
 rtl/fetch_control.sv | 148 ++++++++++++++
 tb/tb_fetch_control.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_control.sv
// fetch_control: instruction fetch sequencer sitting between the PC register,
// instruction memory and a single-entry instruction buffer.
// Optional feature: define FETCH_MISALIGN_CHK_EN to trap misaligned redirect
// targets (sticky fault, enter HALTED). Without it the target is word-aligned
// by clearing its low two bits, and fault is tied low.
module fetch_control #(
    parameter int unsigned PC_STEP = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] current_pc_count,
    output logic [31:0] next_pc_count,
    output logic        wen,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        ihit,
    input  logic [31:0] iload,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        fault
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        FETCH  = 2'b01,
        HALTED = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        iren_c;
    logic        wen_c;
    logic [31:0] next_pc_c;
    logic        misalign;
    logic        stop;

`ifdef FETCH_MISALIGN_CHK_EN
    logic        fault_q, fault_d;
`endif

    // Next-state, buffer update and PC-write decision; priority is
    // halt (incl. misaligned redirect) > redirect > sequential fetch.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        iren_c    = 1'b0;
        wen_c     = 1'b0;
        next_pc_c = current_pc_count + 32'(PC_STEP);
`ifdef FETCH_MISALIGN_CHK_EN
        misalign  = redirect && (redirect_pc[1:0] != 2'b00);
`else
        misalign  = 1'b0;
`endif
        stop      = halt || misalign;

        case (state_q)
            IDLE: begin
                if (stop) begin
                    state_d = HALTED;
                    valid_d = 1'b0;
                end else begin
                    state_d = FETCH;
                    if (redirect) begin
                        wen_c     = 1'b1;
                        next_pc_c = redirect_pc & 32'hFFFF_FFFC;
                        valid_d   = 1'b0;
                    end else if (valid_q && !stall) begin
                        valid_d = 1'b0;
                    end
                end
            end
            FETCH: begin
                if (stop) begin
                    state_d = HALTED;
                    valid_d = 1'b0;
                end else begin
                    // Request only when the buffer is empty or drains this cycle.
                    iren_c = !valid_q || !stall;
                    if (redirect) begin
                        wen_c     = 1'b1;
                        next_pc_c = redirect_pc & 32'hFFFF_FFFC;
                        valid_d   = 1'b0;
                    end else if (iren_c && ihit) begin
                        wen_c   = 1'b1;
                        instr_d = iload;
                        valid_d = 1'b1;
                    end else if (valid_q && !stall) begin
                        valid_d = 1'b0;
                    end
                end
            end
            HALTED: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

`ifdef FETCH_MISALIGN_CHK_EN
        fault_d = fault_q || (misalign && !halt && (state_q != HALTED));
`endif
    end

    // State and instruction buffer registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    // Sticky misaligned-redirect flag, cleared only by reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    // Strobes are forced low while reset is held, independent of state.
    assign iREN          = iren_c && nRST;
    assign wen           = wen_c && nRST;
    assign next_pc_count = next_pc_c;
    assign iaddr         = current_pc_count;
    assign instr         = instr_q;
    assign instr_valid   = valid_q;

endmodule

// File: tb/tb_fetch_control.sv
// Testbench for fetch_control: table-driven cycle vectors with a scoreboard
// queue of expected instruction words, plus hand-written reset, halt and
// misaligned-redirect sequences.
module tb_fetch_control;

    logic        CLK;
    logic        nRST;
    logic [31:0] current_pc_count;
    logic [31:0] next_pc_count;
    logic        wen;
    logic        iREN;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] iload;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fault;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [31:0] sb_q[$];
    logic [31:0] exp_instr = '0;

    typedef struct {
        logic [31:0] pc;
        logic        hit;
        logic        stl;
        logic        rd;
        logic [31:0] rpc;
        logic [31:0] ld;
        logic        hlt;
        logic        e_iren;
        logic        e_wen;
        logic [31:0] e_npc;
        logic        e_valid;
    } vec_t;

    vec_t tbl[16];

    fetch_control #(.PC_STEP(4)) dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .current_pc_count (current_pc_count),
        .next_pc_count    (next_pc_count),
        .wen              (wen),
        .iREN             (iREN),
        .iaddr            (iaddr),
        .ihit             (ihit),
        .iload            (iload),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .halt             (halt),
        .instr            (instr),
        .instr_valid      (instr_valid),
        .fault            (fault)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs on the
    // falling edge, check registered outputs just after the rising edge.
    task automatic apply(input vec_t v, input string tag);
        logic pushed;
        current_pc_count = v.pc;
        ihit             = v.hit;
        stall            = v.stl;
        redirect         = v.rd;
        redirect_pc      = v.rpc;
        iload            = v.ld;
        halt             = v.hlt;
        pushed           = v.e_iren && v.hit && !v.rd && !v.hlt;
        if (pushed) sb_q.push_back(v.ld);
        @(negedge CLK);
        chk({tag, " iaddr"},   iaddr,         v.pc);
        chk({tag, " iREN"},    32'(iREN),     32'(v.e_iren));
        chk({tag, " wen"},     32'(wen),      32'(v.e_wen));
        chk({tag, " next_pc"}, next_pc_count, v.e_npc);
        @(posedge CLK);
        #1;
        chk({tag, " valid"}, 32'(instr_valid), 32'(v.e_valid));
        if (pushed) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s scoreboard: queue empty", tag);
            end else begin
                exp_instr = sb_q.pop_front();
            end
        end
        if (v.e_valid) chk({tag, " instr"}, instr, exp_instr);
    endtask

    initial begin
        //           pc            hit stl rd rpc           ld            hlt iren wen npc           valid
        tbl[0]  = '{32'h0000_0000, 1, 0, 0, 32'h0,        32'hA000_0000, 0, 1, 1, 32'h0000_0004, 1};
        tbl[1]  = '{32'h0000_0004, 1, 0, 0, 32'h0,        32'hA000_0001, 0, 1, 1, 32'h0000_0008, 1};
        tbl[2]  = '{32'h0000_0008, 1, 0, 0, 32'h0,        32'hA000_0002, 0, 1, 1, 32'h0000_000C, 1};
        tbl[3]  = '{32'h0000_000C, 0, 0, 0, 32'h0,        32'hDEAD_0003, 0, 1, 0, 32'h0000_0010, 0};
        tbl[4]  = '{32'h0000_000C, 1, 0, 0, 32'h0,        32'hA000_0004, 0, 1, 1, 32'h0000_0010, 1};
        tbl[5]  = '{32'h0000_0010, 1, 1, 0, 32'h0,        32'hDEAD_0005, 0, 0, 0, 32'h0000_0014, 1};
        tbl[6]  = '{32'h0000_0010, 1, 1, 0, 32'h0,        32'hDEAD_0006, 0, 0, 0, 32'h0000_0014, 1};
        tbl[7]  = '{32'h0000_0010, 1, 1, 0, 32'h0,        32'hDEAD_0007, 0, 0, 0, 32'h0000_0014, 1};
        tbl[8]  = '{32'h0000_0010, 1, 0, 0, 32'h0,        32'hA000_0008, 0, 1, 1, 32'h0000_0014, 1};
        tbl[9]  = '{32'h0000_0020, 1, 0, 1, 32'h0000_0100, 32'hDEAD_0009, 0, 1, 1, 32'h0000_0100, 0};
        tbl[10] = '{32'h0000_0100, 1, 0, 0, 32'h0,        32'hA000_000A, 0, 1, 1, 32'h0000_0104, 1};
        tbl[11] = '{32'hFFFF_FFFC, 1, 0, 0, 32'h0,        32'hA000_000B, 0, 1, 1, 32'h0000_0000, 1};
        tbl[12] = '{32'h0000_0000, 0, 1, 1, 32'h0000_0040, 32'hDEAD_000C, 0, 0, 1, 32'h0000_0040, 0};
        tbl[13] = '{32'h0000_0040, 1, 1, 0, 32'h0,        32'hA000_000D, 0, 1, 1, 32'h0000_0044, 1};
        tbl[14] = '{32'h0000_0044, 0, 0, 0, 32'h0,        32'hDEAD_000E, 0, 1, 0, 32'h0000_0048, 0};
        tbl[15] = '{32'h0000_0048, 1, 0, 0, 32'h0,        32'hA000_000F, 0, 1, 1, 32'h0000_004C, 1};

        // Reset held with active-looking inputs: strobes must stay low.
        nRST             = 1'b0;
        current_pc_count = '0;
        ihit             = 1'b1;
        iload            = 32'h1234_5678;
        stall            = 1'b0;
        redirect         = 1'b1;
        redirect_pc      = 32'h0000_0100;
        halt             = 1'b0;
        @(posedge CLK);
        #1;
        chk("rst iREN",  32'(iREN),        32'h0);
        chk("rst wen",   32'(wen),         32'h0);
        chk("rst instr", instr,            32'h0);
        chk("rst valid", 32'(instr_valid), 32'h0);
        chk("rst fault", 32'(fault),       32'h0);
        nRST     = 1'b1;
        redirect = 1'b0;

        // First cycle after release is IDLE: no request despite ihit.
        apply('{32'h0, 1, 0, 0, 32'h0, 32'hDEAD_FFFF, 0, 0, 0, 32'h4, 0}, "idle");

        for (int i = 0; i < 16; i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
        end

        // Halt beats a same-cycle hit and sticks through redirects.
        apply('{32'h4C, 1, 0, 0, 32'h0,   32'hDEAD_1000, 1, 0, 0, 32'h50, 0}, "h_halt");
        apply('{32'h4C, 1, 0, 1, 32'h200, 32'hDEAD_1001, 0, 0, 0, 32'h50, 0}, "h_rd1");
        apply('{32'h4C, 1, 0, 0, 32'h0,   32'hDEAD_1002, 0, 0, 0, 32'h50, 0}, "h_hit");
        apply('{32'h4C, 1, 0, 1, 32'h300, 32'hDEAD_1003, 0, 0, 0, 32'h50, 0}, "h_rd2");

        // Recovery through reset only.
        nRST = 1'b0;
        #1;
        chk("h_rst iREN", 32'(iREN), 32'h0);
        chk("h_rst wen",  32'(wen),  32'h0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        apply('{32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h4, 0}, "r_idle");
        apply('{32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0, 32'h4, 0}, "r_fetch");

        // Reset mid-cycle with a request outstanding drops it at once.
        #2;
        nRST = 1'b0;
        #1;
        chk("mid_rst iREN", 32'(iREN), 32'h0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        apply('{32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h4, 0}, "m_idle");
        apply('{32'h0, 1, 0, 0, 32'h0, 32'hB000_0000, 0, 1, 1, 32'h4, 1}, "m_fetch");

        // Misaligned redirect target.
`ifdef FETCH_MISALIGN_CHK_EN
        apply('{32'h60, 1, 0, 1, 32'h102, 32'hDEAD_2000, 0, 0, 0, 32'h64, 0}, "mis");
        chk("mis fault", 32'(fault), 32'h1);
        apply('{32'h60, 1, 0, 0, 32'h0,   32'hDEAD_2001, 0, 0, 0, 32'h64, 0}, "mis_after");
        chk("mis fault sticky", 32'(fault), 32'h1);
`else
        apply('{32'h60, 1, 0, 1, 32'h102, 32'hDEAD_2000, 0, 1, 1, 32'h100, 0}, "mis");
        chk("mis fault", 32'(fault), 32'h0);
        apply('{32'h100, 1, 0, 0, 32'h0,  32'hA000_2001, 0, 1, 1, 32'h104, 1}, "mis_after");
        chk("mis fault after", 32'(fault), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
